// File: rtl/shift_load_controller.sv
// Sequencer for one parallel-out shift register: serialises a word MSB-first,
// captures the displaced contents, then checks the register against the word.
module shift_load_controller #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             LoadReq,
    input  logic [WIDTH-1:0] LoadWord,
    output logic             LoadReady,
    input  logic             Abort,
    output logic             ShiftIn,
    output logic             ShiftEn,
    input  logic             ShiftOut,
    input  logic [WIDTH-1:0] ParallelOut,
    output logic             Busy,
    output logic             Done,
    output logic             CheckOk,
    output logic             Aborted,
    output logic [WIDTH-1:0] PrevWord
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [3:0] GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, VERIFY, GAP} state_t;

    state_t           state;
    logic [WIDTH-1:0] word_reg;
    logic [WIDTH-1:0] tx_reg;
    logic [WIDTH-1:0] prev_cap;
    logic [CW-1:0]    count;
    logic [3:0]       gap_cnt;

    assign LoadReady = (state == IDLE);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            word_reg <= '0;
            tx_reg   <= '0;
            prev_cap <= '0;
            count    <= '0;
            gap_cnt  <= '0;
            ShiftIn  <= 1'b0;
            ShiftEn  <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            CheckOk  <= 1'b0;
            Aborted  <= 1'b0;
            PrevWord <= '0;
        end else begin
            Done    <= 1'b0;
            Aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (LoadReq) begin
                        word_reg <= LoadWord;
                        tx_reg   <= LoadWord << 1;
                        ShiftEn  <= 1'b1;
                        ShiftIn  <= LoadWord[WIDTH-1];
                        count    <= '0;
                        Busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Abort outranks the final shift edge, so no Done follows it
                    if (Abort) begin
                        ShiftEn <= 1'b0;
                        ShiftIn <= 1'b0;
                        Aborted <= 1'b1;
                        Busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        prev_cap <= {prev_cap[WIDTH-2:0], ShiftOut};
                        if (count == CW'(WIDTH - 1)) begin
                            ShiftEn <= 1'b0;
                            ShiftIn <= 1'b0;
                            state   <= VERIFY;
                        end else begin
                            count   <= count + 1'b1;
                            ShiftIn <= tx_reg[WIDTH-1];
                            tx_reg  <= tx_reg << 1;
                        end
                    end
                end
                VERIFY: begin
                    CheckOk  <= (ParallelOut == word_reg);
                    PrevWord <= prev_cap;
                    Done     <= 1'b1;
                    if (GAP_CYCLES > 0) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                    end else begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd0) begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
